attopu_fetch: RTL

- Instruction fetch stage directly upstream of the attopu processor core.
- Generates word addresses into a synchronous instruction ROM with 1-cycle read latency and buffers the returned words in a small prefetch FIFO.
- Presents each instruction and its PC to the core over a valid/ready handshake.
- Accepts a redirect (branch/jump) from the core; a redirect flushes all buffered and in-flight fetches.

---
 rtl/attopu_pkg.sv | 19 +
 rtl/attopu_fetch_fifo.sv | 53 +++++
 rtl/attopu_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/attopu_pkg.sv
// Shared types and defaults for the attopu instruction fetch stage.
package attopu_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          DATA_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/attopu_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous clear.
// Clear wins over push/pop so a redirect drops everything, including a same-cycle push.
module attopu_fetch_fifo
  import attopu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  entry_t                i_data,
  input  logic                  i_pop,
  output entry_t                o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                  o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W:0]     r_level;

  // Storage and pointers; storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      if (i_push && !i_pop)      r_level <= r_level + 1'b1;
      else if (!i_push && i_pop) r_level <= r_level - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/attopu_fetch.sv
// Instruction fetch stage: issues ROM reads, buffers words, hands them to the core.
// Issue credit counts buffered plus in-flight words, so the FIFO can never overflow.
module attopu_fetch
  import attopu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int               LVL_W   = $clog2(DEPTH) + 1;
  localparam logic [LVL_W:0]   DEPTH_C = (LVL_W + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_req_q;
  logic               r_kill_q;

  logic               w_redir;
  logic               w_issue;
  logic [LVL_W:0]     w_credit;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  entry_t             w_push_ent;
  entry_t             w_head;

  // Redirects are ignored in BOOT; elsewhere they override everything.
  assign w_redir  = redirect && (r_state != BOOT);
  assign w_credit = {1'b0, w_level} + {{LVL_W{1'b0}}, r_req_q};

  // Next-state and issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_issue     = !w_redir && (w_credit < DEPTH_C);
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
    if (w_redir) w_state_nxt = FLUSH;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOOT;
    else      r_state <= w_state_nxt;
  end

  // Fetch PC, in-flight tracking and kill of a response orphaned by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_req_q    <= 1'b0;
      r_kill_q   <= 1'b0;
    end else begin
      r_req_q  <= w_issue;
      r_kill_q <= w_redir ? r_req_q : 1'b0;
      if (w_redir) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  assign mem_req    = w_issue;
  assign mem_addr   = r_fetch_pc;
  assign w_push     = r_req_q && !r_kill_q;
  assign w_push_ent = '{pc: r_req_pc, instr: mem_rdata};

  assign instr_valid = !w_empty && !redirect;
  assign w_pop       = instr_valid && instr_ready;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign level       = w_level;

  attopu_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_redir),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_empty (w_empty)
  );

endmodule
